// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: segment bit
// positions, the hex glyph set and the dark pattern.
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] BLANK   = 8'h00;

  localparam logic [7:0] GLYPH_0 = 8'hFC;
  localparam logic [7:0] GLYPH_1 = 8'h60;
  localparam logic [7:0] GLYPH_2 = 8'hDA;
  localparam logic [7:0] GLYPH_3 = 8'hF2;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'hB6;
  localparam logic [7:0] GLYPH_6 = 8'hBE;
  localparam logic [7:0] GLYPH_7 = 8'hE0;
  localparam logic [7:0] GLYPH_8 = 8'hFE;
  localparam logic [7:0] GLYPH_9 = 8'hF6;
  localparam logic [7:0] GLYPH_A = 8'hEE;
  localparam logic [7:0] GLYPH_B = 8'h3E;
  localparam logic [7:0] GLYPH_C = 8'h9C;
  localparam logic [7:0] GLYPH_D = 8'h7A;
  localparam logic [7:0] GLYPH_E = 8'h9E;
  localparam logic [7:0] GLYPH_F = 8'h8E;

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-high segment byte (a..g in bits 7..1, dp in bit 0).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here via the
    // default arm), otherwise synthesis infers a latch.
    case (nibble)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      4'hA:    glyph = GLYPH_A;
      4'hB:    glyph = GLYPH_B;
      4'hC:    glyph = GLYPH_C;
      4'hD:    glyph = GLYPH_D;
      4'hE:    glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
  end

  always_comb begin
    seg         = glyph;
    seg[SEG_DP] = glyph[SEG_DP] | dp;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: one digit per slot, two segment
// banks, PWM brightness and frame-synchronous display data updates.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 25000,
  parameter int PWM_BITS   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic [PWM_BITS-1:0]       brightness,
  output logic [7:0]                seg_74,
  output logic [7:0]                seg_30,
  output logic [NUM_DIGITS-1:0]     tub_sel,
  output logic                      frame_done
);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 16 || (NUM_DIGITS % 2) != 0) begin : g_bad_num_digits
    $error("seg_scan_ctrl: NUM_DIGITS must be an even value in 2..16");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seg_scan_ctrl: SCAN_DIV must be at least 2");
  end

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(SCAN_DIV);

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]    IDX_HALF = IDX_W'(NUM_DIGITS / 2);
  localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [PWM_BITS-1:0]     pwm_cnt;
  logic                    tick;
  logic                    wrap_tick;

  logic [4*NUM_DIGITS-1:0] disp_digits, pend_digits;
  logic [NUM_DIGITS-1:0]   disp_dp, disp_blank, pend_dp, pend_blank;
  logic                    pend_valid;

  logic [3:0]              cur_nibble;
  logic                    cur_dp, cur_blank, lit, upper_bank;
  logic [7:0]              glyph, seg_next;
  logic [NUM_DIGITS-1:0]   onehot;

  assign tick      = en && (div_cnt == DIV_LAST);
  assign wrap_tick = tick && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
      pwm_cnt <= '0;
    end else if (en) begin
      pwm_cnt <= pwm_cnt + PWM_ONE;
      if (tick) begin
        div_cnt <= '0;
        idx     <= wrap_tick ? '0 : idx + IDX_ONE;
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end
  end

  // Display registers only ever change at the frame wrap, so a frame is never torn.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      disp_digits <= '0;
      disp_dp     <= '0;
      disp_blank  <= '1;
    end else if (load && wrap_tick) begin
      pend_valid  <= 1'b0;
      disp_digits <= digits_in;
      disp_dp     <= dp_in;
      disp_blank  <= blank_in;
    end else if (load) begin
      pend_valid  <= 1'b1;
    end else if (wrap_tick && pend_valid) begin
      pend_valid  <= 1'b0;
      disp_digits <= pend_digits;
      disp_dp     <= pend_dp;
      disp_blank  <= pend_blank;
    end
  end

  // NOTE: pending data needs no reset; it is only consumed while pend_valid,
  // which is reset, so leaving it out saves reset routing on a wide bank.
  always_ff @(posedge clk) begin
    if (load) begin
      pend_digits <= digits_in;
      pend_dp     <= dp_in;
      pend_blank  <= blank_in;
    end
  end

  assign cur_nibble = disp_digits[{idx, 2'b00} +: 4];
  assign cur_dp     = disp_dp[idx];
  assign cur_blank  = disp_blank[idx];
  assign lit        = (&brightness) || (pwm_cnt < brightness);
  assign upper_bank = (idx >= IDX_HALF);
  assign onehot     = NUM_DIGITS'(1) << idx;

  seg_hex_decode u_decode (
    .nibble (cur_nibble),
    .dp     (cur_dp),
    .seg    (glyph)
  );

  assign seg_next = (lit && !cur_blank) ? glyph : BLANK;

  always_ff @(posedge clk) begin
    if (rst) begin
      tub_sel    <= '0;
      seg_74     <= BLANK;
      seg_30     <= BLANK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap_tick;
      if (en) begin
        tub_sel <= onehot;
        seg_74  <= upper_bank ? seg_next : BLANK;
        seg_30  <= upper_bank ? BLANK : seg_next;
      end else begin
        tub_sel <= '0;
        seg_74  <= BLANK;
        seg_30  <= BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 8 digits, 4 clocks per slot, 4-bit PWM.
module tb_seg_scan_ctrl;

  localparam int ND = 8;

  typedef struct packed {
    logic [31:0] dig;
    logic [7:0]  dp;
    logic [7:0]  blank;
  } frame_t;

  localparam logic [7:0] GLYPH [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  localparam frame_t NO_LOAD = '{dig: 32'h0, dp: 8'h00, blank: 8'hFF};

  logic          clk;
  logic          rst;
  logic          en;
  logic          load;
  logic [31:0]   digits_in;
  logic [7:0]    dp_in;
  logic [7:0]    blank_in;
  logic [3:0]    brightness;
  logic [7:0]    seg_74;
  logic [7:0]    seg_30;
  logic [7:0]    tub_sel;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(4), .PWM_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .brightness (brightness),
    .seg_74     (seg_74),
    .seg_30     (seg_30),
    .tub_sel    (tub_sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until frame_done is seen (bounded); returns the number of clocks taken.
  task automatic wait_frame(input string tag, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!frame_done && cycles < 40);
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s frame_done wait: got %b after %0d clks, expected 1", tag, frame_done, cycles);
    end
  endtask

  // Checks one whole frame starting just after a frame_done sample; optional
  // loads are driven after sample la / lb so they land on the following edge.
  task automatic run_frame(input string tag, input frame_t exp,
                           input int la, input frame_t fa,
                           input int lb, input frame_t fb);
    for (int i = 0; i < 32; i++) begin
      int         k;
      logic [7:0] g, e30, e74, et;
      logic [3:0] nib;
      step();
      k   = i / 4;
      nib = exp.dig[4*k +: 4];
      g   = exp.blank[k] ? 8'h00 : (GLYPH[nib] | {7'b0, exp.dp[k]});
      e30 = (k < 4) ? g : 8'h00;
      e74 = (k < 4) ? 8'h00 : g;
      et  = 8'h01 << k;
      n_checks++;
      if (tub_sel !== et) begin
        n_fail++;
        $display("FAIL %s tub_sel clk %0d: got %h expected %h", tag, i, tub_sel, et);
      end
      n_checks++;
      if (seg_30 !== e30) begin
        n_fail++;
        $display("FAIL %s seg_30 clk %0d: got %h expected %h", tag, i, seg_30, e30);
      end
      n_checks++;
      if (seg_74 !== e74) begin
        n_fail++;
        $display("FAIL %s seg_74 clk %0d: got %h expected %h", tag, i, seg_74, e74);
      end
      n_checks++;
      if (frame_done !== (i == 31)) begin
        n_fail++;
        $display("FAIL %s frame_done clk %0d: got %b expected %b", tag, i, frame_done, (i == 31));
      end
      if (i == la) begin
        load = 1'b1; digits_in = fa.dig; dp_in = fa.dp; blank_in = fa.blank;
      end else if (i == lb) begin
        load = 1'b1; digits_in = fb.dig; dp_in = fb.dp; blank_in = fb.blank;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if (tub_sel !== 8'h00 || seg_30 !== 8'h00 || seg_74 !== 8'h00 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s outputs: got tub=%h s30=%h s74=%h fd=%b expected all 0",
               tag, tub_sel, seg_30, seg_74, frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1;
    digits_in = 32'hAAAA_AAAA; dp_in = 8'h00; blank_in = 8'h00; brightness = 4'hF;
    step();
    step();
    check_idle("reset");
    n_checks++;
    if (dut.pend_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset pend_valid: got %b expected 0", dut.pend_valid);
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
    step();
    check_idle("post_reset_disabled");
  endtask

  task automatic test_scan();
    int cyc;
    digits_in = 32'h7654_3210; dp_in = 8'h00; blank_in = 8'h00;
    load = 1'b1; en = 1'b1;
    step();
    load = 1'b0;
    wait_frame("scan", cyc);
    n_checks++;
    if (cyc != 31) begin
      n_fail++;
      $display("FAIL scan first wrap latency: got %0d clks expected 31", cyc);
    end
    run_frame("scan", '{32'h7654_3210, 8'h00, 8'h00}, -1, NO_LOAD, -1, NO_LOAD);
  endtask

  task automatic test_midframe_load();
    run_frame("midload_old", '{32'h7654_3210, 8'h00, 8'h00},
              10, '{32'hFFFF_FFFF, 8'h00, 8'h00}, -1, NO_LOAD);
    run_frame("midload_new", '{32'hFFFF_FFFF, 8'h00, 8'h00}, -1, NO_LOAD, -1, NO_LOAD);
  endtask

  task automatic test_wrap_load();
    run_frame("wrapload_old", '{32'hFFFF_FFFF, 8'h00, 8'h00},
              5, '{32'h1111_1111, 8'h00, 8'h00}, 30, '{32'h2222_2222, 8'h00, 8'h00});
    n_checks++;
    if (dut.pend_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrapload pend_valid: got %b expected 0", dut.pend_valid);
    end
    run_frame("wrapload_new", '{32'h2222_2222, 8'h00, 8'h00}, -1, NO_LOAD, -1, NO_LOAD);
    run_frame("wrapload_stable", '{32'h2222_2222, 8'h00, 8'h00}, -1, NO_LOAD, -1, NO_LOAD);
  endtask

  task automatic test_blank_dp();
    run_frame("blankdp_old", '{32'h2222_2222, 8'h00, 8'h00},
              3, '{32'h2222_2228, 8'h01, 8'h08}, -1, NO_LOAD);
    run_frame("blankdp", '{32'h2222_2228, 8'h01, 8'h08},
              3, '{32'h8888_8888, 8'h00, 8'h00}, -1, NO_LOAD);
  endtask

  task automatic test_brightness();
    int lit_cnt;
    brightness = 4'h4;
    for (int w = 0; w < 2; w++) begin
      lit_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        step();
        if ((seg_30 | seg_74) != 8'h00) lit_cnt++;
      end
      n_checks++;
      if (lit_cnt != 4) begin
        n_fail++;
        $display("FAIL bright4 window %0d lit clks: got %0d expected 4", w, lit_cnt);
      end
    end
    brightness = 4'h0;
    for (int i = 0; i < 32; i++) begin
      step();
      n_checks++;
      if (seg_30 !== 8'h00 || seg_74 !== 8'h00 || !$onehot(tub_sel)) begin
        n_fail++;
        $display("FAIL bright0 clk %0d: got s30=%h s74=%h tub=%h expected 00 00 onehot",
                 i, seg_30, seg_74, tub_sel);
      end
    end
    brightness = 4'hF;
  endtask

  task automatic test_disable_reset();
    int         cyc;
    logic [7:0] exp_tub [3] = '{8'h02, 8'h02, 8'h04};
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (tub_sel !== 8'h02) begin
      n_fail++;
      $display("FAIL disable pre tub_sel: got %h expected 02", tub_sel);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle("disabled");
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (tub_sel !== exp_tub[i]) begin
        n_fail++;
        $display("FAIL resume tub_sel clk %0d: got %h expected %h", i, tub_sel, exp_tub[i]);
      end
    end
    digits_in = 32'h9999_9999; dp_in = 8'hFF; blank_in = 8'h00; load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("midframe_reset");
    n_checks++;
    if (dut.pend_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset pend_valid: got %b expected 0", dut.pend_valid);
    end
    wait_frame("after_reset", cyc);
    n_checks++;
    if (cyc != 32) begin
      n_fail++;
      $display("FAIL after_reset wrap latency: got %0d clks expected 32", cyc);
    end
    run_frame("after_reset", NO_LOAD, -1, NO_LOAD, -1, NO_LOAD);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0;
    digits_in = '0; dp_in = '0; blank_in = '0; brightness = 4'hF;
    test_reset();
    test_scan();
    test_midframe_load();
    test_wrap_load();
    test_blank_dp();
    test_brightness();
    test_disable_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of scanned digits; legal values are even numbers 2..16.
REQ-002 Parameter SCAN_DIV, default 25000: clk cycles per digit slot; legal range is 2 or more.
REQ-003 Parameter PWM_BITS, default 4: brightness resolution.
REQ-004 clk  in  1: single clock; all logic rising-edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 en  in  1: scan enable.
REQ-007 load  in  1: one-cycle strobe that captures new display data.
REQ-008 digits_in  in  4*NUM_DIGITS: hex nibble per digit, digit k at bits [4k+3:4k].
REQ-009 dp_in  in  NUM_DIGITS: decimal point per digit.
REQ-010 blank_in  in  NUM_DIGITS: 1 = digit dark.
REQ-011 brightness  in  PWM_BITS: display duty level.
REQ-012 seg_74  out  8: segments for the upper bank (digits NUM_DIGITS/2..NUM_DIGITS-1).
REQ-013 seg_30  out  8: segments for the lower bank (digits 0..NUM_DIGITS/2-1).
REQ-014 tub_sel  out  NUM_DIGITS: one-hot digit select, bit k = digit k.
REQ-015 frame_done  out  1: one-cycle pulse at frame wrap.

Function
REQ-016 Segment byte format, active-high: bit7..bit1 = a..g, bit0 = dp.
REQ-017 Glyphs SHALL be: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, B=3E, C=9C, D=7A, E=9E, F=8E; dp_in[k] ORs bit0.
REQ-018 Divider div_cnt counts 0..SCAN_DIV-1 while en=1; tick asserts on the cycle div_cnt==SCAN_DIV-1, and div_cnt wraps to 0 on that cycle.
REQ-019 Digit index idx advances on tick; N-1 wraps to 0.
REQ-020 frame_done pulses for exactly one cycle, registered, on the cycle after the tick that wraps idx from N-1 to 0.
REQ-021 load captures digits_in/dp_in/blank_in into pending registers and sets the pending flag; a repeated load before the frame boundary overwrites the pending data.
REQ-022 At the wrapping tick, pending data SHALL transfer to the display registers if the pending flag is set, and the flag SHALL clear; display data never changes mid-frame.
REQ-023 If load coincides with the wrapping tick, the load data SHALL go directly to the display registers and the pending flag SHALL end clear.
REQ-024 PWM counter (PWM_BITS wide) increments every clk, free-running.
REQ-025 Lit = (brightness == all-ones) OR (pwm_cnt < brightness); brightness 0 means fully dark.
REQ-026 Outputs are registered with 1-cycle latency from an idx change.
REQ-027 tub_sel = onehot(idx) whenever en=1, independent of lit/blank.
REQ-028 The active bank shows the glyph when lit and not blank, otherwise 00; the inactive bank is always 00.
REQ-029 With en=0: div_cnt, idx and pwm_cnt hold; tub_sel, seg_74, seg_30 are 0 next cycle; load and pending transfer are still accepted; no tick and no frame_done.
REQ-030 On en rising, scanning resumes from the held idx/div_cnt.

Reset
REQ-031 On rst=1 at a clk edge: div_cnt=0, idx=0, pwm_cnt=0, pending flag=0.
REQ-032 Reset values: display digits=0, dp=0, blank=all-ones; outputs tub_sel=0, seg_74=00, seg_30=00, frame_done=0.
REQ-033 rst has priority over load and en; rst mid-frame discards pending data.

Structure
REQ-034 Package seg_pkg holds the glyph constants (REQ-017), the segment bit positions, and the BLANK=00 constant.
REQ-035 A combinational sub-module seg_hex_decode (nibble, dp -> 8-bit segments) is instantiated once, on the muxed digit.
REQ-036 Parameter legality (REQ-001, REQ-002) is checked at elaboration.

Verification (NUM_DIGITS=8, SCAN_DIV=4, PWM_BITS=4, brightness=F unless stated)
REQ-037 Reset release -> load digits=76543210, blank=00, en=1 -> tub_sel steps 01,02,..,80, one step per 4 clks; seg_30 = FC,60,DA,F2 then seg_74 = 66,B6,BE,E0, inactive bank 00.
REQ-038 Load digits=FFFFFFFF mid-frame -> no change until after the idx7->0 wrap; frame_done pulses once per 32 clks.
REQ-039 Load coincident with the wrap tick -> new glyphs appear from digit 0 of the next frame; pending flag 0.
REQ-040 brightness=4 -> active segments nonzero on exactly 4 of every 16 clks; brightness=0 -> segments always 00 with tub_sel still scanning.
REQ-041 blank_in[3]=1, dp_in[0]=1, digit0=8 -> slot 3 shows 00; slot 0 shows FF.
REQ-042 en=0 for 10 clks mid-slot, then rst pulse mid-frame with a pending load -> outputs 0 while disabled, idx held; after rst, all outputs 0 and the pending data is never displayed.
